res_station: RTL and testbench
==============================

# res_station

Unified reservation station for the Qu back end, sitting directly downstream of `front_end`/`rename`. It accepts renamed micro-ops with operand tags and any operand values already available, captures missing operands from the common data bus (CDB) by tag match, and issues ready micro-ops one per cycle to the execution stage through a registered valid/ready port. It also reports a free slot address and a full flag so rename can steer its writes.

## Interface
Parameters:
- `RS_DEPTH`, 8: number of entries, power of two, ≥2.
- `TAG_WIDTH`, `PHY_RF_ADDR_WIDTH`: physical-register tag width.
- `DATA_WIDTH`, 32: operand width.
- `OP_WIDTH`, `UOP_WIDTH`: opaque micro-op payload width, carried unmodified.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all entries and the issue register.
- `wr_en`  in  1  write request from rename.
- `wr_addr`  in  `$clog2(RS_DEPTH)`  target entry.
- `wr_op`  in  `OP_WIDTH`  micro-op payload.
- `wr_rd_tag`  in  `TAG_WIDTH`  destination physical register.
- `wr_rs1_tag`, `wr_rs2_tag`  in  `TAG_WIDTH`  source tags.
- `wr_rs1_ready`, `wr_rs2_ready`  in  1  operand value already valid.
- `wr_rs1_data`, `wr_rs2_data`  in  `DATA_WIDTH`  operand values; only meaningful when the matching ready bit is set.
- `free_addr`  out  `$clog2(RS_DEPTH)`  lowest-index invalid entry.
- `full`  out  1  all entries valid.
- `cdb_valid`  in  1  broadcast valid.
- `cdb_tag`  in  `TAG_WIDTH`  broadcast tag.
- `cdb_data`  in  `DATA_WIDTH`  broadcast value.
- `issue_valid`  out  1  issue register holds a micro-op.
- `issue_ready`  in  1  execution stage accepts.
- `issue_op`  out  `OP_WIDTH`; `issue_rd_tag`  out  `TAG_WIDTH`; `issue_rs1_data`, `issue_rs2_data`  out  `DATA_WIDTH`.

## Operation
- Entry state: `valid`, op, rd tag, and per source {tag, ready, data}. Entry is eligible when `valid && rs1_ready && rs2_ready`.
- Write: on `wr_en` with entry `wr_addr` invalid, load all fields and set `valid`. A write to a valid entry is dropped, and existing contents are preserved.
- Wakeup: for each valid entry and source with ready=0 and tag==`cdb_tag` while `cdb_valid`, capture `cdb_data` and set ready.
- Write/CDB bypass: in the same cycle, if a written source has ready=0 and its tag matches a valid CDB, it is stored ready with `cdb_data`.
- Select: a fixed-priority encoder picks the lowest-index eligible entry.
- Issue register load: when `!issue_valid || issue_ready`, the selected entry (if any) is copied into the issue register and its `valid` is cleared in the same edge. If nothing is eligible, `issue_valid` drops to 0 when the current micro-op fires.
- Issue register contents are held stable while `issue_valid && !issue_ready`.
- `free_addr`/`full`: combinational from the current `valid` vector. When `full` is 1, `free_addr` is 0.
- Flush: highest priority. At the edge it clears every `valid` bit and `issue_valid`, and ignores the same-cycle write, wakeup and issue load.
- Reset: all `valid`, ready bits and `issue_valid` are 0. Issue payload outputs are 0, `full`=0 and `free_addr`=0.

## Timing
- Write in cycle N with both sources ready: entry valid from N+1; `issue_valid`=1 from N+2 if the issue register is free and no lower-index entry is eligible.
- CDB wakeup in cycle N: entry eligible in N+1; earliest `issue_valid` is N+2.
- Throughput: one issue per cycle with `issue_ready` held at 1.
- A slot freed by an issue load at edge N is reported in `free_addr` from N+1. There is no same-cycle free-and-write.
- Asserting `rst` mid-operation clears state immediately, independent of `clk`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> `issue_valid`=0, `full`=0 and `free_addr`=0 immediately; prior entries never issue.
- Ready write: write addr 0 (op=0x15, rd=5, both sources ready, data 0x11/0x22) at cycle 0 -> cycle 2: `issue_valid`=1, `issue_rd_tag`=5, `issue_rs1_data`=0x11, `issue_rs2_data`=0x22.
- Wakeup and bypass:
  - Write entry 1 with rs1 tag 9 not ready, then CDB tag 9 / 0xDEAD two cycles later -> issues with `issue_rs1_data`=0xDEAD.
  - Write with the CDB on tag 9 in the same cycle -> issues at cycle 2.
- Fill and backpressure: write all 8 entries ready with `issue_ready`=0 -> `full`=1 and issue contents stable. Raise `issue_ready` -> entries issue in index order 0..7, one per cycle, and `full` drops after the first load.
- Collision and full: a write to an occupied entry -> original payload issues and the new one is lost. After the issue drains the entry, a write to it issues normally.
- Flush: with 3 entries valid and `issue_valid`=1, pulse `flush` while writing entry 5 -> next cycle `issue_valid`=0, `free_addr`=0, `full`=0, and nothing issues afterwards.

Source files
------------

// File: rtl/res_station.sv
// Unified reservation station: holds renamed micro-ops until both operands are
// available (directly or via CDB wakeup), then issues the oldest-index ready entry.
module res_station #(
  parameter int RS_DEPTH          = 8,
  parameter int PHY_RF_ADDR_WIDTH = 6,
  parameter int TAG_WIDTH         = PHY_RF_ADDR_WIDTH,
  parameter int DATA_WIDTH        = 32,
  parameter int UOP_WIDTH         = 16,
  parameter int OP_WIDTH          = UOP_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,

  input  logic                        wr_en,
  input  logic [$clog2(RS_DEPTH)-1:0] wr_addr,
  input  logic [OP_WIDTH-1:0]         wr_op,
  input  logic [TAG_WIDTH-1:0]        wr_rd_tag,
  input  logic [TAG_WIDTH-1:0]        wr_rs1_tag,
  input  logic [TAG_WIDTH-1:0]        wr_rs2_tag,
  input  logic                        wr_rs1_ready,
  input  logic                        wr_rs2_ready,
  input  logic [DATA_WIDTH-1:0]       wr_rs1_data,
  input  logic [DATA_WIDTH-1:0]       wr_rs2_data,

  output logic [$clog2(RS_DEPTH)-1:0] free_addr,
  output logic                        full,

  input  logic                        cdb_valid,
  input  logic [TAG_WIDTH-1:0]        cdb_tag,
  input  logic [DATA_WIDTH-1:0]       cdb_data,

  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OP_WIDTH-1:0]         issue_op,
  output logic [TAG_WIDTH-1:0]        issue_rd_tag,
  output logic [DATA_WIDTH-1:0]       issue_rs1_data,
  output logic [DATA_WIDTH-1:0]       issue_rs2_data
);

  localparam int AW = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0]   valid;
  logic [RS_DEPTH-1:0]   rs1_rdy;
  logic [RS_DEPTH-1:0]   rs2_rdy;
  logic [OP_WIDTH-1:0]   op_q       [RS_DEPTH];
  logic [TAG_WIDTH-1:0]  rd_tag_q   [RS_DEPTH];
  logic [TAG_WIDTH-1:0]  rs1_tag_q  [RS_DEPTH];
  logic [TAG_WIDTH-1:0]  rs2_tag_q  [RS_DEPTH];
  logic [DATA_WIDTH-1:0] rs1_data_q [RS_DEPTH];
  logic [DATA_WIDTH-1:0] rs2_data_q [RS_DEPTH];

  logic                  wr_accept;
  logic                  wr_rs1_hit;
  logic                  wr_rs2_hit;
  logic                  wr_rs1_rdy_in;
  logic                  wr_rs2_rdy_in;
  logic [DATA_WIDTH-1:0] wr_rs1_data_in;
  logic [DATA_WIDTH-1:0] wr_rs2_data_in;

  logic [RS_DEPTH-1:0]   eligible;
  logic                  sel_found;
  logic [AW-1:0]         sel_idx;
  logic                  issue_load;
  logic                  issue_take;

  // Writes only land in empty slots; an operand broadcast in the same cycle is captured on the way in.
  assign wr_accept      = wr_en && !valid[wr_addr];
  assign wr_rs1_hit     = cdb_valid && !wr_rs1_ready && (cdb_tag == wr_rs1_tag);
  assign wr_rs2_hit     = cdb_valid && !wr_rs2_ready && (cdb_tag == wr_rs2_tag);
  assign wr_rs1_rdy_in  = wr_rs1_ready || wr_rs1_hit;
  assign wr_rs2_rdy_in  = wr_rs2_ready || wr_rs2_hit;
  assign wr_rs1_data_in = wr_rs1_hit ? cdb_data : wr_rs1_data;
  assign wr_rs2_data_in = wr_rs2_hit ? cdb_data : wr_rs2_data;

  assign eligible = valid & rs1_rdy & rs2_rdy;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = AW'(i);
      end
    end
  end

  assign issue_load = !issue_valid || issue_ready;
  assign issue_take = issue_load && sel_found;

  always_comb begin
    free_addr = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_addr = AW'(i);
      end
    end
  end

  assign full = &valid;

  // Write, wakeup and issue-dequeue never target the same entry in one cycle:
  // writes need an invalid slot, the other two need a valid one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= '0;
      rs1_rdy <= '0;
      rs2_rdy <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        op_q[i]       <= '0;
        rd_tag_q[i]   <= '0;
        rs1_tag_q[i]  <= '0;
        rs2_tag_q[i]  <= '0;
        rs1_data_q[i] <= '0;
        rs2_data_q[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid[i] && cdb_valid) begin
          if (!rs1_rdy[i] && (rs1_tag_q[i] == cdb_tag)) begin
            rs1_rdy[i]    <= 1'b1;
            rs1_data_q[i] <= cdb_data;
          end
          if (!rs2_rdy[i] && (rs2_tag_q[i] == cdb_tag)) begin
            rs2_rdy[i]    <= 1'b1;
            rs2_data_q[i] <= cdb_data;
          end
        end
        if (wr_accept && (wr_addr == AW'(i))) begin
          valid[i]      <= 1'b1;
          op_q[i]       <= wr_op;
          rd_tag_q[i]   <= wr_rd_tag;
          rs1_tag_q[i]  <= wr_rs1_tag;
          rs2_tag_q[i]  <= wr_rs2_tag;
          rs1_rdy[i]    <= wr_rs1_rdy_in;
          rs2_rdy[i]    <= wr_rs2_rdy_in;
          rs1_data_q[i] <= wr_rs1_data_in;
          rs2_data_q[i] <= wr_rs2_data_in;
        end
        if (issue_take && (sel_idx == AW'(i))) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

  // Issue register only advances when empty or when the consumer takes the current micro-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid    <= 1'b0;
      issue_op       <= '0;
      issue_rd_tag   <= '0;
      issue_rs1_data <= '0;
      issue_rs2_data <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (issue_load) begin
      issue_valid <= sel_found;
      if (sel_found) begin
        issue_op       <= op_q[sel_idx];
        issue_rd_tag   <= rd_tag_q[sel_idx];
        issue_rs1_data <= rs1_data_q[sel_idx];
        issue_rs2_data <= rs2_data_q[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_res_station.sv
// Self-checking bench for res_station: vector table for single micro-op latency/wakeup
// cases, hand sequences for fill/backpressure, collision, flush and async reset.
module tb_res_station;

  localparam int RS_DEPTH   = 8;
  localparam int TAG_WIDTH  = 6;
  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH   = 16;
  localparam int AW         = 3;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [OP_WIDTH-1:0]   wr_op;
  logic [TAG_WIDTH-1:0]  wr_rd_tag;
  logic [TAG_WIDTH-1:0]  wr_rs1_tag;
  logic [TAG_WIDTH-1:0]  wr_rs2_tag;
  logic                  wr_rs1_ready;
  logic                  wr_rs2_ready;
  logic [DATA_WIDTH-1:0] wr_rs1_data;
  logic [DATA_WIDTH-1:0] wr_rs2_data;
  logic [AW-1:0]         free_addr;
  logic                  full;
  logic                  cdb_valid;
  logic [TAG_WIDTH-1:0]  cdb_tag;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [OP_WIDTH-1:0]   issue_op;
  logic [TAG_WIDTH-1:0]  issue_rd_tag;
  logic [DATA_WIDTH-1:0] issue_rs1_data;
  logic [DATA_WIDTH-1:0] issue_rs2_data;

  res_station #(
    .RS_DEPTH   (RS_DEPTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .OP_WIDTH   (OP_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_op          (wr_op),
    .wr_rd_tag      (wr_rd_tag),
    .wr_rs1_tag     (wr_rs1_tag),
    .wr_rs2_tag     (wr_rs2_tag),
    .wr_rs1_ready   (wr_rs1_ready),
    .wr_rs2_ready   (wr_rs2_ready),
    .wr_rs1_data    (wr_rs1_data),
    .wr_rs2_data    (wr_rs2_data),
    .free_addr      (free_addr),
    .full           (full),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_op       (issue_op),
    .issue_rd_tag   (issue_rd_tag),
    .issue_rs1_data (issue_rs1_data),
    .issue_rs2_data (issue_rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]         addr;
    logic [OP_WIDTH-1:0]   op;
    logic [TAG_WIDTH-1:0]  rd;
    logic [TAG_WIDTH-1:0]  t1;
    logic                  r1;
    logic [DATA_WIDTH-1:0] d1;
    logic [TAG_WIDTH-1:0]  t2;
    logic                  r2;
    logic [DATA_WIDTH-1:0] d2;
    int                    cdb_cyc;
    logic [TAG_WIDTH-1:0]  cdb_t;
    logic [DATA_WIDTH-1:0] cdb_d;
    logic [DATA_WIDTH-1:0] exp1;
    logic [DATA_WIDTH-1:0] exp2;
    int                    exp_lat;
  } vec_t;

  typedef struct {
    logic [OP_WIDTH-1:0]   op;
    logic [TAG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] d1;
    logic [DATA_WIDTH-1:0] d2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic pushExp(input logic [OP_WIDTH-1:0] op, input logic [TAG_WIDTH-1:0] rd,
                         input logic [DATA_WIDTH-1:0] d1, input logic [DATA_WIDTH-1:0] d2);
    exp_t e;
    e.op = op; e.rd = rd; e.d1 = d1; e.d2 = d2;
    exp_q.push_back(e);
  endtask

  // Scoreboard consumer: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      checkOutput("issue_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("issue_op", 64'(issue_op), 64'(e.op));
        checkOutput("issue_rd_tag", 64'(issue_rd_tag), 64'(e.rd));
        checkOutput("issue_rs1_data", 64'(issue_rs1_data), 64'(e.d1));
        checkOutput("issue_rs2_data", 64'(issue_rs2_data), 64'(e.d2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_op = '0; wr_rd_tag = '0;
    wr_rs1_tag = '0; wr_rs2_tag = '0; wr_rs1_ready = 1'b0; wr_rs2_ready = 1'b0;
    wr_rs1_data = '0; wr_rs2_data = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic driveWrite(input logic [AW-1:0] a, input logic [OP_WIDTH-1:0] op,
                            input logic [TAG_WIDTH-1:0] rd,
                            input logic [DATA_WIDTH-1:0] d1, input logic [DATA_WIDTH-1:0] d2);
    wr_en = 1'b1; wr_addr = a; wr_op = op; wr_rd_tag = rd;
    wr_rs1_tag = 6'd1; wr_rs2_tag = 6'd2; wr_rs1_ready = 1'b1; wr_rs2_ready = 1'b1;
    wr_rs1_data = d1; wr_rs2_data = d2;
  endtask

  task automatic writeEntry(input logic [AW-1:0] a, input logic [OP_WIDTH-1:0] op,
                            input logic [TAG_WIDTH-1:0] rd,
                            input logic [DATA_WIDTH-1:0] d1, input logic [DATA_WIDTH-1:0] d2);
    driveWrite(a, op, rd, d1, d2);
    tick();
    wr_en = 1'b0;
  endtask

  // One micro-op written at cycle 0; latency is the first cycle issue_valid is seen high.
  task automatic applyStimulus(input vec_t v, input int idx);
    int lat;
    lat = -1;
    pushExp(v.op, v.rd, v.exp1, v.exp2);
    for (int cyc = 0; cyc < 16 && lat < 0; cyc++) begin
      wr_en = (cyc == 0); wr_addr = v.addr; wr_op = v.op; wr_rd_tag = v.rd;
      wr_rs1_tag = v.t1; wr_rs1_ready = v.r1; wr_rs1_data = v.d1;
      wr_rs2_tag = v.t2; wr_rs2_ready = v.r2; wr_rs2_data = v.d2;
      cdb_valid = (cyc == v.cdb_cyc); cdb_tag = v.cdb_t; cdb_data = v.cdb_d;
      @(negedge clk);
      if (issue_valid) lat = cyc;
      tick();
    end
    idleInputs();
    checkOutput($sformatf("vec%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    checkOutput($sformatf("vec%0d_drained", idx), 64'(exp_q.size()), 64'd0);
  endtask

  function automatic vec_t mkVec(input logic [AW-1:0] a, input logic [OP_WIDTH-1:0] op,
      input logic [TAG_WIDTH-1:0] rd,
      input logic [TAG_WIDTH-1:0] t1, input logic r1, input logic [DATA_WIDTH-1:0] d1,
      input logic [TAG_WIDTH-1:0] t2, input logic r2, input logic [DATA_WIDTH-1:0] d2,
      input int cc, input logic [TAG_WIDTH-1:0] ct, input logic [DATA_WIDTH-1:0] cd,
      input logic [DATA_WIDTH-1:0] e1, input logic [DATA_WIDTH-1:0] e2, input int lat);
    vec_t v;
    v.addr = a; v.op = op; v.rd = rd; v.t1 = t1; v.r1 = r1; v.d1 = d1;
    v.t2 = t2; v.r2 = r2; v.d2 = d2; v.cdb_cyc = cc; v.cdb_t = ct; v.cdb_d = cd;
    v.exp1 = e1; v.exp2 = e2; v.exp_lat = lat;
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = mkVec(3'd0, 16'h15, 6'd5, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22,
                    -1, 6'd0, 32'h0, 32'h11, 32'h22, 2);
    vecs[1] = mkVec(3'd1, 16'h21, 6'd6, 6'd9, 1'b0, 32'hBAD0BAD0, 6'd3, 1'b1, 32'h33,
                    2, 6'd9, 32'hDEAD, 32'hDEAD, 32'h33, 4);
    vecs[2] = mkVec(3'd1, 16'h22, 6'd7, 6'd9, 1'b0, 32'hBAD0BAD0, 6'd4, 1'b1, 32'h44,
                    0, 6'd9, 32'hCAFE, 32'hCAFE, 32'h44, 2);
    vecs[3] = mkVec(3'd7, 16'h37, 6'd12, 6'd9, 1'b1, 32'h11, 6'd9, 1'b0, 32'hBAD0BAD0,
                    1, 6'd9, 32'hBEEF, 32'h11, 32'hBEEF, 3);
    vecs[4] = mkVec(3'd3, 16'h43, 6'd13, 6'd20, 1'b0, 32'hBAD1, 6'd20, 1'b0, 32'hBAD2,
                    0, 6'd20, 32'h1234, 32'h1234, 32'h1234, 2);
    vecs[5] = mkVec(3'd4, 16'h54, 6'd14, 6'd5, 1'b1, 32'h77, 6'd10, 1'b0, 32'hBAD3,
                    3, 6'd10, 32'hABCD, 32'h77, 32'hABCD, 5);

    idleInputs();
    issue_ready = 1'b1;
    rst = 1'b1;
    #3;
    checkOutput("reset_issue_valid", 64'(issue_valid), 64'd0);
    checkOutput("reset_full", 64'(full), 64'd0);
    checkOutput("reset_free_addr", 64'(free_addr), 64'd0);
    checkOutput("reset_issue_op", 64'(issue_op), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    // Fill behind a stalled issue register, then drain in index order.
    $display("[TB] fill and backpressure");
    issue_ready = 1'b0;
    pushExp(16'h99, 6'd30, 32'hA1, 32'hA2);
    writeEntry(3'd0, 16'h99, 6'd30, 32'hA1, 32'hA2);
    tick();
    for (int i = 0; i < RS_DEPTH; i++) begin
      driveWrite(AW'(i), 16'(16'h40 + i), 6'(8 + i), 32'(32'h100 + i), 32'(32'h200 + i));
      pushExp(16'(16'h40 + i), 6'(8 + i), 32'(32'h100 + i), 32'(32'h200 + i));
      @(negedge clk);
      checkOutput($sformatf("fill_free_addr%0d", i), 64'(free_addr), 64'(i));
      checkOutput($sformatf("fill_not_full%0d", i), 64'(full), 64'd0);
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_full", 64'(full), 64'd1);
      checkOutput("stall_free_addr", 64'(free_addr), 64'd0);
      checkOutput("stall_issue_valid", 64'(issue_valid), 64'd1);
      checkOutput("stall_issue_op", 64'(issue_op), 64'h99);
      checkOutput("stall_issue_rs1", 64'(issue_rs1_data), 64'hA1);
      tick();
    end
    issue_ready = 1'b1;
    @(negedge clk);
    checkOutput("drain_full_before_load", 64'(full), 64'd1);
    for (int k = 0; k < RS_DEPTH; k++) begin
      @(negedge clk);
      checkOutput($sformatf("drain_valid%0d", k), 64'(issue_valid), 64'd1);
      if (k == 0) begin
        checkOutput("drain_full_dropped", 64'(full), 64'd0);
        checkOutput("drain_free_addr", 64'(free_addr), 64'd0);
      end
    end
    @(negedge clk);
    checkOutput("drain_idle", 64'(issue_valid), 64'd0);
    checkOutput("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // Second write to an occupied slot must be dropped.
    $display("[TB] collision");
    pushExp(16'h51, 6'd11, 32'h5A, 32'h5B);
    writeEntry(3'd2, 16'h51, 6'd11, 32'h5A, 32'h5B);
    writeEntry(3'd2, 16'h52, 6'd12, 32'h6A, 32'h6B);
    repeat (4) tick();
    checkOutput("collision_sb_empty", 64'(exp_q.size()), 64'd0);
    pushExp(16'h53, 6'd13, 32'h7A, 32'h7B);
    writeEntry(3'd2, 16'h53, 6'd13, 32'h7A, 32'h7B);
    repeat (4) tick();
    checkOutput("rewrite_sb_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("rewrite_issue_idle", 64'(issue_valid), 64'd0);

    // Flush with pending entries and a held issue register, plus a concurrent write.
    $display("[TB] flush");
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) writeEntry(AW'(i), 16'(16'h60 + i), 6'(20 + i), 32'h1, 32'h2);
    @(negedge clk);
    checkOutput("preflush_issue_valid", 64'(issue_valid), 64'd1);
    tick();
    flush = 1'b1;
    driveWrite(3'd5, 16'h65, 6'd25, 32'h3, 32'h4);
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    checkOutput("flush_issue_valid", 64'(issue_valid), 64'd0);
    checkOutput("flush_free_addr", 64'(free_addr), 64'd0);
    checkOutput("flush_full", 64'(full), 64'd0);
    issue_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("postflush_idle", 64'(issue_valid), 64'd0);
    end
    tick();

    // Asynchronous reset in the middle of a cycle.
    $display("[TB] async reset");
    issue_ready = 1'b0;
    writeEntry(3'd0, 16'h70, 6'd1, 32'h1, 32'h2);
    writeEntry(3'd1, 16'h71, 6'd2, 32'h1, 32'h2);
    writeEntry(3'd2, 16'h72, 6'd3, 32'h1, 32'h2);
    writeEntry(3'd0, 16'h73, 6'd4, 32'h1, 32'h2);
    @(negedge clk);
    checkOutput("prereset_issue_valid", 64'(issue_valid), 64'd1);
    checkOutput("prereset_free_addr", 64'(free_addr), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("areset_issue_valid", 64'(issue_valid), 64'd0);
    checkOutput("areset_full", 64'(full), 64'd0);
    checkOutput("areset_free_addr", 64'(free_addr), 64'd0);
    checkOutput("areset_issue_op", 64'(issue_op), 64'd0);
    checkOutput("areset_issue_rs1", 64'(issue_rs1_data), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    issue_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("postreset_idle", 64'(issue_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
